uart_frame_parser: RTL

//  Consumes the byte stream from the UART receiver (data + data_ready strobe) and extracts framed packets.

---
 rtl/uart_frame_parser_pkg.sv | 11 +
 rtl/uart_frame_parser_rise_detect.sv | 13 +
 rtl/uart_frame_parser.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_pkg.sv
// uart_frame_parser_pkg: shared SOF byte, parser state encoding and error codes for the UART framing path.
package uart_frame_parser_pkg;
  localparam logic [7:0] SOF = 8'hA5;
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM} state_t;
  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_LEN     = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_CSUM    = 2'b11
  } err_t;
endpackage

// File: rtl/uart_frame_parser_rise_detect.sv
// rise_detect: one-cycle strobe on the rising edge of a level; the history bit is the only state.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);
  logic prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) prev <= 1'b0;
    else prev <= in;
  assign pulse = in & ~prev;
endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: extracts A5/LEN/payload frames from the UART RX byte stream.
// Define UART_FRAME_CHECKSUM_EN to require a trailing XOR checksum byte (LEN ^ payload).
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);
  state_t           state;
  logic             acc;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] tcnt;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  rise_detect u_rise (.clk(clk), .rst(rst), .in(rx_ready), .pulse(acc));

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= S_IDLE;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      busy       <= 1'b0;
      rem        <= '0;
      tcnt       <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      // An accept wins over a timeout firing in the same cycle.
      if (acc) begin
        tcnt <= '0;
        case (state)
          S_IDLE: if (rx_data == SOF) begin
            state <= S_LEN;
            busy  <= 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
            csum  <= '0;
`endif
          end
          S_LEN: begin
`ifdef UART_FRAME_CHECKSUM_EN
            csum <= rx_data;
`endif
            if (rx_data > 8'(MAX_LEN)) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
            end else if (rx_data == 8'd0) begin
`ifdef UART_FRAME_CHECKSUM_EN
              state      <= S_CSUM;
`else
              state      <= S_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
`endif
            end else begin
              rem   <= CNT_W'(rx_data);
              state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            out_data  <= rx_data;
            out_valid <= 1'b1;
            rem       <= rem - 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
            csum      <= csum ^ rx_data;
            if (rem == CNT_W'(1)) state <= S_CSUM;
`else
            if (rem == CNT_W'(1)) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
`endif
          end
`ifdef UART_FRAME_CHECKSUM_EN
          S_CSUM: begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= (rx_data == csum);
            frame_err  <= (rx_data != csum);
            if (rx_data != csum) err_code <= ERR_CSUM;
          end
`endif
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (state != S_IDLE) begin
        if (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tcnt      <= '0;
          state     <= S_IDLE;
          busy      <= 1'b0;
          frame_err <= 1'b1;
          err_code  <= ERR_TIMEOUT;
        end else tcnt <= tcnt + 1'b1;
      end
    end
endmodule
